// File: rtl/obstacle_culler.sv
// Streaming polygon culler: bounding-box screen test into a double-buffered obstacle store.
// Ports: vertex beats (valid/last/x/y), screen rect, frame_done swap, registered front-bank read port, frame status.
module obstacle_culler #(
  parameter int WORLD_BITS       = 32,
  parameter int MAX_NUM_VERTICES = 8,
  parameter int MAX_OBSTACLES    = 16,
  parameter int MARGIN           = 0
) (
  input  logic                                       clk_in,
  input  logic                                       rst_in,
  input  logic                                       valid_in,
  input  logic                                       last_in,
  input  logic signed [WORLD_BITS-1:0]               x_in,
  input  logic signed [WORLD_BITS-1:0]               y_in,
  input  logic signed [WORLD_BITS-1:0]               screen_min_x,
  input  logic signed [WORLD_BITS-1:0]               screen_max_x,
  input  logic signed [WORLD_BITS-1:0]               screen_min_y,
  input  logic signed [WORLD_BITS-1:0]               screen_max_y,
  input  logic                                       frame_done_in,
  input  logic [$clog2(MAX_OBSTACLES)-1:0]           rd_obs_idx,
  input  logic [$clog2(MAX_NUM_VERTICES)-1:0]        rd_vtx_idx,
  output logic signed [WORLD_BITS-1:0]               rd_x_out,
  output logic signed [WORLD_BITS-1:0]               rd_y_out,
  output logic [$clog2(MAX_NUM_VERTICES+1)-1:0]      rd_num_sides_out,
  output logic [$clog2(MAX_OBSTACLES+1)-1:0]         num_obstacles_out,
  output logic                                       obs_overflow_out,
  output logic                                       vtx_overflow_out,
  output logic                                       done_out
);

  localparam int OW = $clog2(MAX_OBSTACLES);
  localparam int VW = $clog2(MAX_NUM_VERTICES);
  localparam int SW = $clog2(MAX_NUM_VERTICES+1);
  localparam int CW = $clog2(MAX_OBSTACLES+1);
  localparam int EW = WORLD_BITS + 1;
  localparam logic signed [EW-1:0] LP_M = EW'(MARGIN);
  localparam int MB = WORLD_BITS - 1;

  logic signed [WORLD_BITS-1:0] r_vx [2][MAX_OBSTACLES][MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0] r_vy [2][MAX_OBSTACLES][MAX_NUM_VERTICES];
  logic [SW-1:0]                r_sides [2][MAX_OBSTACLES];

  logic                         r_bank;
  logic                         r_open;
  logic [CW-1:0]                r_curr;
  logic [SW-1:0]                r_cnt;
  logic signed [WORLD_BITS-1:0] r_minx, r_maxx, r_miny, r_maxy;
  logic                         r_drop, r_trunc;

  logic                         w_back, w_full, w_room;
  logic                         w_store, w_trunc_beat;
  logic                         w_keep, w_commit, w_drop_beat;
  logic [VW-1:0]                w_widx;
  logic [SW-1:0]                w_ncnt;
  logic [CW-1:0]                w_curr_nx;
  logic signed [WORLD_BITS-1:0] w_minx, w_maxx, w_miny, w_maxy;
  logic signed [EW-1:0]         w_lo_x, w_hi_x, w_lo_y, w_hi_y;

  assign w_back  = ~r_bank;
  assign w_full  = (r_curr == CW'(MAX_OBSTACLES));
  // A fresh polygon always has room; an open one only until its slots are used.
  assign w_room  = ~r_open | (r_cnt < SW'(MAX_NUM_VERTICES));
  assign w_store = valid_in & ~w_full & w_room;
  assign w_trunc_beat = valid_in & ~w_full & ~w_room;
  assign w_widx  = r_open ? r_cnt[VW-1:0] : '0;
  assign w_ncnt  = r_open ? r_cnt + SW'(1) : SW'(1);

  assign w_minx = (r_open && r_minx < x_in) ? r_minx : x_in;
  assign w_maxx = (r_open && r_maxx > x_in) ? r_maxx : x_in;
  assign w_miny = (r_open && r_miny < y_in) ? r_miny : y_in;
  assign w_maxy = (r_open && r_maxy > y_in) ? r_maxy : y_in;

  // Widened screen bounds carry one extra bit so the margin cannot wrap.
  assign w_lo_x = $signed({screen_min_x[MB], screen_min_x}) - LP_M;
  assign w_hi_x = $signed({screen_max_x[MB], screen_max_x}) + LP_M;
  assign w_lo_y = $signed({screen_min_y[MB], screen_min_y}) - LP_M;
  assign w_hi_y = $signed({screen_max_y[MB], screen_max_y}) + LP_M;

  assign w_keep = ($signed({w_minx[MB], w_minx}) <= w_hi_x) &&
                  ($signed({w_maxx[MB], w_maxx}) >= w_lo_x) &&
                  ($signed({w_miny[MB], w_miny}) <= w_hi_y) &&
                  ($signed({w_maxy[MB], w_maxy}) >= w_lo_y);

  assign w_commit    = valid_in & last_in & w_keep & ~w_full;
  assign w_drop_beat = valid_in & last_in & w_keep & w_full;
  assign w_curr_nx   = r_curr + CW'(w_commit);

  always_ff @(posedge clk_in) begin
    if (w_store) begin
      r_vx[w_back][r_curr[OW-1:0]][w_widx] <= x_in;
      r_vy[w_back][r_curr[OW-1:0]][w_widx] <= y_in;
      r_sides[w_back][r_curr[OW-1:0]]      <= w_ncnt;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_bank            <= 1'b0;
      r_open            <= 1'b0;
      r_curr            <= '0;
      r_cnt             <= '0;
      r_minx            <= '0;
      r_maxx            <= '0;
      r_miny            <= '0;
      r_maxy            <= '0;
      r_drop            <= 1'b0;
      r_trunc           <= 1'b0;
      rd_x_out          <= '0;
      rd_y_out          <= '0;
      rd_num_sides_out  <= '0;
      num_obstacles_out <= '0;
      obs_overflow_out  <= 1'b0;
      vtx_overflow_out  <= 1'b0;
      done_out          <= 1'b0;
    end else begin
      done_out         <= frame_done_in;
      rd_x_out         <= r_vx[r_bank][rd_obs_idx][rd_vtx_idx];
      rd_y_out         <= r_vy[r_bank][rd_obs_idx][rd_vtx_idx];
      rd_num_sides_out <= r_sides[r_bank][rd_obs_idx];
      if (frame_done_in) begin
        // The coincident beat is folded into the frame being published.
        r_bank            <= ~r_bank;
        num_obstacles_out <= w_curr_nx;
        obs_overflow_out  <= r_drop | w_drop_beat;
        vtx_overflow_out  <= r_trunc | w_trunc_beat;
        r_curr            <= '0;
        r_drop            <= 1'b0;
        r_trunc           <= 1'b0;
        r_open            <= 1'b0;
      end else begin
        r_curr <= w_curr_nx;
        if (w_drop_beat)  r_drop  <= 1'b1;
        if (w_trunc_beat) r_trunc <= 1'b1;
        if (valid_in) begin
          r_open <= ~last_in;
          r_minx <= w_minx;
          r_maxx <= w_maxx;
          r_miny <= w_miny;
          r_maxy <= w_maxy;
          if (w_store) r_cnt <= w_ncnt;
        end
      end
    end
  end

endmodule

// File: doc/obstacle_culler.md
# obstacle_culler

Streaming polygon culler for the render path. Accepts obstacle vertices one per beat, builds each polygon's axis-aligned bounding box, keeps the polygon only if that box overlaps the screen rectangle widened by a margin, and stores kept polygons in a double-buffered store. On each frame boundary the banks swap, so the renderer reads a stable, complete obstacle list through a registered read port while the next frame is collected.

## Interface
- WORLD_BITS, 32, signed world-coordinate width
- MAX_NUM_VERTICES, 8, vertex slots per stored polygon
- MAX_OBSTACLES, 16, polygon slots per bank
- MARGIN, 0, non-negative world units added on every side of the screen rectangle

- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- valid_in  in  1  vertex beat valid
- last_in  in  1  beat is the final vertex of its polygon (qualified by valid_in)
- x_in, y_in  in  WORLD_BITS signed  vertex coordinates
- screen_min_x, screen_max_x, screen_min_y, screen_max_y  in  WORLD_BITS signed  screen rectangle; sampled on every beat
- frame_done_in  in  1  single-cycle pulse: end of frame, swap banks
- rd_obs_idx  in  $clog2(MAX_OBSTACLES)  front-bank polygon select
- rd_vtx_idx  in  $clog2(MAX_NUM_VERTICES)  vertex select
- rd_x_out, rd_y_out  out  WORLD_BITS signed  selected vertex, front bank
- rd_num_sides_out  out  $clog2(MAX_NUM_VERTICES+1)  vertex count of selected polygon
- num_obstacles_out  out  $clog2(MAX_OBSTACLES+1)  kept-polygon count of front bank
- obs_overflow_out  out  1  front frame dropped at least one kept polygon (bank full)
- vtx_overflow_out  out  1  front frame truncated at least one polygon (too many vertices)
- done_out  out  1  single-cycle pulse: swap completed, front bank updated

## Operation
- Per polygon, back bank, slot curr_idx: first beat (no polygon open) writes vertex 0, sets min/max x/y to the beat, side count 1; later beats write vertex[side count], update min/max, increment count.
- Beats beyond MAX_NUM_VERTICES: not stored, still update min/max, set frame-local vtx_trunc flag.
- On a beat with last_in: keep test uses min/max including that beat. Keep iff min_x <= screen_max_x+MARGIN and max_x >= screen_min_x-MARGIN and same for y. Bounds computed at WORLD_BITS+1 bits, signed; no wrap. Edge contact counts as overlap.
- Kept and curr_idx < MAX_OBSTACLES: curr_idx increments (slot committed). Kept and bank full: polygon discarded, obs_drop flag set. Not kept: slot reused by next polygon.
- Single-beat polygon (valid_in and last_in together): point, tested as degenerate box.
- When curr_idx == MAX_OBSTACLES, incoming beats are ignored for storage but last_in still evaluated to set obs_drop.
- frame_done_in: front/back bank select toggles; num_obstacles_out <= curr_idx; obs_overflow_out/vtx_overflow_out <= frame flags; curr_idx, flags, open-polygon state clear; done_out pulses next cycle.
- Polygon open (no last_in yet) at frame_done_in: partial polygon discarded, not counted.
- frame_done_in with valid_in same cycle: beat is processed first (belongs to ending frame; if last_in and kept it is counted), then swap.
- Read port reads front bank only; contents unchanged until next swap. rd_num_sides_out for indices >= num_obstacles_out is don't-care.

## Timing
- Reset (async assert, sync to clk_in on release): all outputs 0, bank select 0, curr_idx 0, no polygon open, flags clear. Reset mid-polygon or mid-frame discards everything; front bank reads 0 count.
- Input accepted every cycle; no backpressure.
- Read latency 1 cycle: rd_* reflect indices sampled at the previous edge.
- done_out and num_obstacles_out/overflow outputs update on the edge after frame_done_in is sampled; done_out high exactly one cycle.
- Back-to-back frame_done_in pulses: each swaps; second publishes count 0.
- Storage per bank: MAX_OBSTACLES x MAX_NUM_VERTICES x 2 x WORLD_BITS plus side counts.

## Test plan
- Screen (0,0)-(100,100), MARGIN 0; triangle (10,10),(20,10),(15,30) last, frame_done -> done_out 1 cycle later, num_obstacles_out 1, read (0,2) returns (15,30), rd_num_sides_out 3.
- Quad (-50,-50),(-10,-50),(-10,-10),(-50,-10) with MARGIN 0 -> count 0; same with MARGIN 10 -> count 1. Square spanning whole screen with no vertex inside -> kept.
- MAX_OBSTACLES=16: 18 on-screen triangles, frame_done -> count 16, obs_overflow_out 1; next empty frame -> count 0, flag 0.
- 10-vertex polygon, MAX_NUM_VERTICES=8, 9th vertex only on-screen -> kept, rd_num_sides_out 8, vtx_overflow_out 1.
- frame_done_in same cycle as last_in of on-screen polygon -> counted in published frame; frame_done_in mid-polygon -> partial dropped; read port stable during next frame's writes.
- rst_in asserted mid-polygon asynchronously -> outputs 0 immediately; subsequent frame counts from 0.
